// File: rtl/jbi_min_rq_rhq_rd_ctl.sv
// RHQ read controller: issues array reads against the synced write pointer, buffers returned headers.
// Latency: write pointer advance to hdr_vld is 3 cycles; sustains 1 header/cycle with hdr_ack held high.
// Backpressure: reads are credited against free output FIFO slots, so hdr_ack=0 stalls issue without data loss.
module jbi_min_rq_rhq_rd_ctl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 64,
  parameter int OBUF_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic [ADDR_WIDTH:0]   rhq_wptr,
  input  logic [DATA_WIDTH-1:0] rhq_rdata,
  output logic                  rhq_csn_rd,
  output logic [ADDR_WIDTH-1:0] rhq_raddr,
  output logic [ADDR_WIDTH:0]   rhq_rptr,
  output logic                  hdr_vld,
  output logic [DATA_WIDTH-1:0] hdr_data,
  input  logic                  hdr_ack,
  output logic                  rhq_empty
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int IW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam int SW = CW + 2;

  // Next array entry to read; runs ahead of rhq_rptr by the reads still in flight.
  logic [PW-1:0]         rptr_iss;
  // A read was sampled by the array at the last edge; rhq_rdata is valid this cycle.
  logic                  rd_pend;

  logic [DATA_WIDTH-1:0] obuf [OBUF_DEPTH];
  logic [IW-1:0]         head;
  logic [IW-1:0]         tail;
  logic [CW-1:0]         occ;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [SW-1:0]         occ_n;
  logic [SW-1:0]         pend_cnt;
  logic [PW-1:0]         wr_dist;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    if (idx == IW'(OBUF_DEPTH - 1)) next_idx = '0;
    else                            next_idx = idx + IW'(1);
  endfunction

  assign rhq_empty = (rptr_iss == rhq_wptr);
  assign hdr_vld   = (occ != '0);
  assign hdr_data  = obuf[head];
  assign pop       = hdr_vld & hdr_ack;
  assign push      = rd_pend;

  // Credit check: slots left after this cycle's pop must cover every read already in flight plus the new one.
  assign occ_n    = SW'(occ) - SW'(pop);
  assign pend_cnt = SW'(!rhq_csn_rd) + SW'(rd_pend);
  assign issue    = !rhq_empty && ((occ_n + pend_cnt) < SW'(OBUF_DEPTH));

  // Read issue: drive the array strobe and address, advance the issue pointer.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rhq_csn_rd <= 1'b1;
      rhq_raddr  <= '0;
      rptr_iss   <= '0;
    end else if (issue) begin
      rhq_csn_rd <= 1'b0;
      rhq_raddr  <= rptr_iss[ADDR_WIDTH-1:0];
      rptr_iss   <= rptr_iss + PW'(1);
    end else begin
      rhq_csn_rd <= 1'b1;
    end
  end

  // Array latency tracking and freed-entry pointer: an entry is released once its data is captured.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_pend  <= 1'b0;
      rhq_rptr <= '0;
    end else begin
      rd_pend <= !rhq_csn_rd;
      if (push) rhq_rptr <= rhq_rptr + PW'(1);
    end
  end

  // Output FIFO: capture at tail, pop at head; simultaneous push and pop keep occupancy constant.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) obuf[i] <= '0;
    end else begin
      if (push) begin
        obuf[tail] <= rhq_rdata;
        tail       <= next_idx(tail);
      end
      if (pop) head <= next_idx(head);
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

  assign wr_dist = rhq_wptr - rhq_rptr;

  // Capturing into a full FIFO means the credit accounting has been violated.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_l)
    !(push && !pop && (occ == CW'(OBUF_DEPTH))));

  // Writer must never move backwards or run more than a full queue ahead of the freed pointer.
  a_wptr_sane: assert property (@(posedge clk) disable iff (!rst_l)
    (wr_dist <= PW'(1 << ADDR_WIDTH)));

endmodule

// File: tb/tb_jbi_min_rq_rhq_rd_ctl.sv
// Directed bench for the RHQ read controller with a behavioural 16x64 array model.
// Latency: checks the 3-cycle write-to-header path and 1 header/cycle streaming.
// Backpressure: holds hdr_ack low to verify credit-limited issue and stable head data.
module tb_jbi_min_rq_rhq_rd_ctl;

  logic        clk;
  logic        rst_l;
  logic [4:0]  rhq_wptr;
  logic [63:0] rhq_rdata;
  logic        rhq_csn_rd;
  logic [3:0]  rhq_raddr;
  logic [4:0]  rhq_rptr;
  logic        hdr_vld;
  logic [63:0] hdr_data;
  logic        hdr_ack;
  logic        rhq_empty;

  logic [63:0] mem [16];
  logic [63:0] got_q [$];
  logic [3:0]  ra_q [$];
  int          n_checks;
  int          n_fail;
  int          rd_cnt;
  int          wait_cyc;

  jbi_min_rq_rhq_rd_ctl #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .OBUF_DEPTH(3)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .rhq_wptr   (rhq_wptr),
    .rhq_rdata  (rhq_rdata),
    .rhq_csn_rd (rhq_csn_rd),
    .rhq_raddr  (rhq_raddr),
    .rhq_rptr   (rhq_rptr),
    .hdr_vld    (hdr_vld),
    .hdr_data   (hdr_data),
    .hdr_ack    (hdr_ack),
    .rhq_empty  (rhq_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: read sampled on the edge where csn is low, data lands in the listen flop.
  always @(posedge clk) if (!rhq_csn_rd) rhq_rdata <= mem[rhq_raddr];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // With hdr_ack high, gather up to n headers and the read addresses issued meanwhile.
  task automatic collect(input int n, input int max_cyc);
    got_q.delete();
    ra_q.delete();
    for (int c = 0; c < max_cyc && got_q.size() < n; c++) begin
      if (!rhq_csn_rd) ra_q.push_back(rhq_raddr);
      if (hdr_vld && hdr_ack) got_q.push_back(hdr_data);
      tick();
    end
    chk("collect_cnt", 64'(got_q.size()), 64'(n));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_l     = 1'b0;
    rhq_wptr  = 5'd0;
    hdr_ack   = 1'b0;
    rhq_rdata = 64'd0;
    for (int i = 0; i < 16; i++) mem[i] = 64'h1000_0000_0000_0000 + 64'(i);

    // Reset state
    tick(); tick();
    chk("rst_csn", 64'(rhq_csn_rd), 64'd1);
    chk("rst_vld", 64'(hdr_vld), 64'd0);
    chk("rst_rptr", 64'(rhq_rptr), 64'd0);
    chk("rst_empty", 64'(rhq_empty), 64'd1);
    chk("rst_data", hdr_data, 64'd0);
    rst_l = 1'b1;
    tick();

    // Single entry: wptr advances at edge N
    mem[0] = 64'hDEAD_BEEF_0123_4567;
    tick();
    rhq_wptr = 5'd1;
    #1 chk("one_notempty", 64'(rhq_empty), 64'd0);
    tick();
    chk("one_csn_n1", 64'(rhq_csn_rd), 64'd0);
    chk("one_raddr_n1", 64'(rhq_raddr), 64'd0);
    chk("one_vld_n1", 64'(hdr_vld), 64'd0);
    tick();
    chk("one_csn_n2", 64'(rhq_csn_rd), 64'd1);
    chk("one_vld_n2", 64'(hdr_vld), 64'd0);
    tick();
    chk("one_vld_n3", 64'(hdr_vld), 64'd1);
    chk("one_data_n3", hdr_data, 64'hDEAD_BEEF_0123_4567);
    chk("one_rptr_n3", 64'(rhq_rptr), 64'd1);
    chk("one_empty_n3", 64'(rhq_empty), 64'd1);
    hdr_ack = 1'b1;
    tick();
    chk("one_vld_popped", 64'(hdr_vld), 64'd0);
    hdr_ack = 1'b0;

    // Backpressure: 8 entries at addresses 1..8, ack held low
    for (int i = 1; i <= 8; i++) mem[i] = 64'hB000_0000_0000_0000 + 64'(i * 3);
    rhq_wptr = 5'd9;
    rd_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!rhq_csn_rd) rd_cnt++;
      if (c == 5) chk("bp_data_mid", hdr_data, mem[1]);
    end
    chk("bp_reads", 64'(rd_cnt), 64'd3);
    chk("bp_vld", 64'(hdr_vld), 64'd1);
    chk("bp_data", hdr_data, mem[1]);
    chk("bp_rptr", 64'(rhq_rptr), 64'd4);
    hdr_ack = 1'b1;
    collect(8, 40);
    for (int i = 0; i < 8; i++) chk($sformatf("bp_hdr%0d", i), got_q[i], mem[i + 1]);
    chk("bp_ra_cnt", 64'(ra_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("bp_ra%0d", i), 64'(ra_q[i]), 64'(i + 4));
    chk("bp_end_vld", 64'(hdr_vld), 64'd0);
    chk("bp_end_rptr", 64'(rhq_rptr), 64'd9);

    // Reset asserted mid-burst: outputs clear within the cycle
    rhq_wptr = 5'd13;
    tick(); tick(); tick();
    rst_l = 1'b0;
    rhq_wptr = 5'd0;
    #2;
    chk("mid_rst_csn", 64'(rhq_csn_rd), 64'd1);
    chk("mid_rst_raddr", 64'(rhq_raddr), 64'd0);
    chk("mid_rst_vld", 64'(hdr_vld), 64'd0);
    chk("mid_rst_data", hdr_data, 64'd0);
    chk("mid_rst_rptr", 64'(rhq_rptr), 64'd0);
    chk("mid_rst_empty", 64'(rhq_empty), 64'd1);
    tick();
    rst_l = 1'b1;
    tick();

    // Streaming: 16 entries with ack held high
    for (int i = 0; i < 16; i++) mem[i] = 64'h5000_0000_0000_0000 + 64'(i * 7);
    rhq_wptr = 5'd16;
    wait_cyc = 0;
    while (!hdr_vld && wait_cyc < 10) begin
      tick();
      wait_cyc++;
    end
    chk("st_latency", 64'(wait_cyc), 64'd3);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("st_vld%0d", i), 64'(hdr_vld), 64'd1);
      chk($sformatf("st_hdr%0d", i), hdr_data, mem[i]);
      tick();
    end
    chk("st_end_vld", 64'(hdr_vld), 64'd0);
    chk("st_end_rptr", 64'(rhq_rptr), 64'd16);
    chk("st_end_empty", 64'(rhq_empty), 64'd1);

    // Wrap: bring pointers to 14, then write 4 entries across the wrap
    rst_l = 1'b0;
    rhq_wptr = 5'd0;
    tick();
    rst_l = 1'b1;
    tick();
    rhq_wptr = 5'd14;
    collect(14, 40);
    tick(); tick();
    chk("wr_pre_rptr", 64'(rhq_rptr), 64'd14);
    mem[14] = 64'hA0A0_0000_0000_000E;
    mem[15] = 64'hA0A0_0000_0000_000F;
    mem[0]  = 64'hA0A0_0000_0000_0010;
    mem[1]  = 64'hA0A0_0000_0000_0011;
    rhq_wptr = 5'd18;
    collect(4, 20);
    chk("wr_ra0", 64'(ra_q[0]), 64'd14);
    chk("wr_ra1", 64'(ra_q[1]), 64'd15);
    chk("wr_ra2", 64'(ra_q[2]), 64'd0);
    chk("wr_ra3", 64'(ra_q[3]), 64'd1);
    chk("wr_hdr0", got_q[0], 64'hA0A0_0000_0000_000E);
    chk("wr_hdr1", got_q[1], 64'hA0A0_0000_0000_000F);
    chk("wr_hdr2", got_q[2], 64'hA0A0_0000_0000_0010);
    chk("wr_hdr3", got_q[3], 64'hA0A0_0000_0000_0011);
    chk("wr_rptr", 64'(rhq_rptr), 64'd18);
    chk("wr_msb", 64'(rhq_rptr[4]), 64'd1);
    chk("wr_empty", 64'(rhq_empty), 64'd1);
    chk("wr_vld", 64'(hdr_vld), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
